inst_encoder: RTL

//  Encodes decoded instruction fields (format, regs, funct, 32-bit signed immediate) into a 32-bit RV32I word.

---
 rtl/inst_encoder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: turns decoded instruction fields back into a 32-bit RV32I word.
// Words leave through a two-entry buffer (output register plus skid entry) so
// the producer side can keep streaming while the consumer stalls for a cycle.
// Every accepted word is tagged with a running byte address, and words whose
// immediate cannot be represented are replaced by a NOP and flagged.
`timescale 1ns/1ps
module inst_encoder #(
   parameter int               ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter bit               CHECK_RANGE = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_inst,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   output logic              err_sticky
);

   localparam logic [6:0]  OP_ALUI = 7'b0010011;
   localparam logic [6:0]  OP_LOAD = 7'b0000011;
   localparam logic [6:0]  OP_S    = 7'b0100011;
   localparam logic [6:0]  OP_B    = 7'b1100011;
   localparam logic [6:0]  OP_JAL  = 7'b1101111;
   localparam logic [6:0]  OP_JALR = 7'b1100111;
   localparam logic [31:0] NOP     = 32'h00000013;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

   occ_t               state_q, state_d;
   logic signed [31:0] sImm;
   logic [31:0]        encInst;
   logic               encErr;
   logic               rangeBad;
   logic               illegalFmt;
   logic [31:0]        outInst_q, skidInst_q;
   logic [ADDR_W-1:0]  outAddr_q, skidAddr_q, nextAddr_q;
   logic               outErr_q, skidErr_q, errSticky_q;
   logic               inXfer, outXfer;
   logic               loadOut, loadSkid, moveSkid;

   assign sImm       = in_imm;
   assign in_ready   = (state_q != TWO);
   assign out_valid  = (state_q != EMPTY);
   assign inXfer     = in_valid & in_ready & ~clear;
   assign outXfer    = out_valid & out_ready;
   assign out_inst   = outInst_q;
   assign out_addr   = outAddr_q;
   assign out_err    = outErr_q;
   assign err_sticky = errSticky_q;

   // Pack the fields for the requested format and decide whether the immediate fits it
   always_comb begin
      encInst    = '0;
      rangeBad   = 1'b0;
      illegalFmt = 1'b0;
      case (in_fmt)
         3'd0: begin
            encInst  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_ALUI};
            rangeBad = (sImm < -2048) || (sImm > 2047);
         end
         3'd1: begin
            encInst  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            rangeBad = (sImm < -2048) || (sImm > 2047);
         end
         3'd2: begin
            encInst  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
            rangeBad = (sImm < -2048) || (sImm > 2047);
         end
         3'd3: begin
            encInst  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], OP_B};
            rangeBad = (sImm < -4096) || (sImm > 4094) || in_imm[0];
         end
         3'd4: begin
            encInst  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            rangeBad = (sImm < -1048576) || (sImm > 1048574) || in_imm[0];
         end
         3'd5: begin
            encInst  = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
            rangeBad = (sImm < -2048) || (sImm > 2047);
         end
         default: illegalFmt = 1'b1;
      endcase
      encErr = illegalFmt | (CHECK_RANGE & rangeBad);
      if (encErr) begin
         encInst = NOP;
      end
   end

   // Buffer occupancy register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Occupancy next state and which buffer entry gets written this cycle
   always_comb begin
      state_d  = state_q;
      loadOut  = 1'b0;
      loadSkid = 1'b0;
      moveSkid = 1'b0;
      if (clear) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (inXfer) begin
                  state_d = ONE;
                  loadOut = 1'b1;
               end
            end
            ONE: begin
               if (inXfer && outXfer) begin
                  loadOut = 1'b1;
               end else if (inXfer) begin
                  state_d  = TWO;
                  loadSkid = 1'b1;
               end else if (outXfer) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (outXfer) begin
                  state_d  = ONE;
                  moveSkid = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Output register and skid entry; output only changes on load or skid promotion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outInst_q  <= '0;
         outAddr_q  <= BASE_ADDR;
         outErr_q   <= 1'b0;
         skidInst_q <= '0;
         skidAddr_q <= BASE_ADDR;
         skidErr_q  <= 1'b0;
      end else begin
         if (loadOut) begin
            outInst_q <= encInst;
            outAddr_q <= nextAddr_q;
            outErr_q  <= encErr;
         end else if (moveSkid) begin
            outInst_q <= skidInst_q;
            outAddr_q <= skidAddr_q;
            outErr_q  <= skidErr_q;
         end
         if (loadSkid) begin
            skidInst_q <= encInst;
            skidAddr_q <= nextAddr_q;
            skidErr_q  <= encErr;
         end
      end
   end

   // Address counter advances per accepted word; sticky error latches on emitted error words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nextAddr_q  <= BASE_ADDR;
         errSticky_q <= 1'b0;
      end else if (clear) begin
         nextAddr_q  <= BASE_ADDR;
         errSticky_q <= 1'b0;
      end else begin
         if (inXfer) begin
            nextAddr_q <= nextAddr_q + ADDR_W'(4);
         end
         if (outXfer && outErr_q) begin
            errSticky_q <= 1'b1;
         end
      end
   end

endmodule
